// File: rtl/chain_code_tracer_if.sv
// Chain-code output stream: Freeman code with valid/ready backpressure.
interface chain_code_tracer_if;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;

  modport master (output code, output code_valid, input code_ready);
  modport slave  (input code, input code_valid, output code_ready);
endinterface

// File: rtl/chain_code_tracer.sv
// Binary-image boundary tracer: raster scan for start pixel and area, then 8-connected
// Moore tracing streaming Freeman codes. Define CHAIN_DIFF_EN for differential codes.
module chain_code_tracer #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned X_W   = 6,
  parameter int unsigned Y_W   = 6,
  parameter int unsigned LEN_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en_i,
  input  logic [Y_W-1:0]       wr_row_i,
  input  logic [IMG_W-1:0]     wr_data_i,
  input  logic                 start_i,
  output logic                 busy_o,
  chain_code_tracer_if.master  cc,
  output logic                 done_o,
  output logic [1:0]           error_o,
  output logic [LEN_W-1:0]     perimeter_o,
  output logic [X_W+Y_W:0]     area_o,
  output logic [X_W-1:0]       start_x_o,
  output logic [Y_W-1:0]       start_y_o
);

  localparam int unsigned A_W     = X_W + Y_W + 1;
  localparam int unsigned MAX_LEN = (32'd1 << LEN_W) - 32'd1;

  typedef enum logic [1:0] {IDLE, SCAN, TRACE, DONE} state_e;

  state_e           state_q, state_d;
  logic [Y_W-1:0]   row_q, row_d;
  logic             found_q, found_d;
  logic [A_W-1:0]   area_q, area_d;
  logic [X_W-1:0]   sx_q, sx_d, cur_x_q, cur_x_d;
  logic [Y_W-1:0]   sy_q, sy_d, cur_y_q, cur_y_d;
  logic [2:0]       dir_q, dir_d, first_q, first_d;
  logic             first_vld_q, first_vld_d;
  logic             valid_q, valid_d;
  logic [LEN_W-1:0] perim_q, perim_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [1:0]       error_q, error_d;

  logic [IMG_W-1:0] img_q [IMG_H];

  logic [A_W-1:0]   row_pop, area_sum;
  logic [X_W-1:0]   row_low;
  logic             row_any;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [2:0]       sel_s, sel_first, nb_dir, nb_try;
  logic             sel_fvld, nb_found, stop;
  logic [LEN_W-1:0] perim_inc;
  int               nx, ny;

  function automatic int dir_dx(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: return 1;
      3'd3, 3'd4, 3'd5: return -1;
      default:          return 0;
    endcase
  endfunction

  function automatic int dir_dy(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: return -1;
      3'd5, 3'd6, 3'd7: return 1;
      default:          return 0;
    endcase
  endfunction

  // Image rows are frozen while busy so tracing sees a stable picture.
  always_ff @(posedge clk) begin
    if (wr_en_i && !busy_q && (32'(wr_row_i) < IMG_H)) begin
      img_q[wr_row_i] <= wr_data_i;
    end
  end

  always_comb begin
    row_pop = '0;
    row_low = '0;
    row_any = 1'b0;
    for (int j = int'(IMG_W) - 1; j >= 0; j--) begin
      if (img_q[row_q][j]) begin
        row_pop = row_pop + A_W'(1);
        row_low = X_W'(j);
        row_any = 1'b1;
      end
    end
  end

  // Position/search-direction the next code is selected from: in TRACE this is the
  // state after the currently presented code is accepted, giving one code per cycle.
  always_comb begin
    sel_x     = cur_x_q;
    sel_y     = cur_y_q;
    sel_s     = 3'd5;
    sel_fvld  = 1'b0;
    sel_first = first_q;
    if (state_q == SCAN) begin
      sel_x = found_q ? sx_q : row_low;
      sel_y = found_q ? sy_q : row_q;
    end else if (state_q == TRACE) begin
      sel_x     = X_W'(int'(cur_x_q) + dir_dx(dir_q));
      sel_y     = Y_W'(int'(cur_y_q) + dir_dy(dir_q));
      sel_s     = dir_q[0] ? dir_q + 3'd6 : dir_q + 3'd7;
      sel_fvld  = 1'b1;
      sel_first = first_vld_q ? first_q : dir_q;
    end
  end

  always_comb begin
    nb_found = 1'b0;
    nb_dir   = '0;
    nb_try   = '0;
    nx       = 0;
    ny       = 0;
    for (int k = 0; k < 8; k++) begin
      nb_try = sel_s + 3'(k);
      nx     = int'(sel_x) + dir_dx(nb_try);
      ny     = int'(sel_y) + dir_dy(nb_try);
      if (!nb_found && nx >= 0 && nx < int'(IMG_W) && ny >= 0 && ny < int'(IMG_H)) begin
        if (img_q[ny[Y_W-1:0]][nx[X_W-1:0]]) begin
          nb_found = 1'b1;
          nb_dir   = nb_try;
        end
      end
    end
    stop = sel_fvld && (sel_x == sx_q) && (sel_y == sy_q) && (nb_dir == sel_first);
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    found_d     = found_q;
    area_d      = area_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    dir_d       = dir_q;
    first_d     = first_q;
    first_vld_d = first_vld_q;
    valid_d     = valid_q;
    perim_d     = perim_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    area_sum    = area_q + row_pop;
    perim_inc   = perim_q + LEN_W'(1);
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = SCAN;
          row_d       = '0;
          found_d     = 1'b0;
          area_d      = '0;
          perim_d     = '0;
          error_d     = '0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          valid_d     = 1'b0;
          first_vld_d = 1'b0;
        end
      end
      SCAN: begin
        area_d = area_sum;
        row_d  = row_q + Y_W'(1);
        if (!found_q && row_any) begin
          found_d = 1'b1;
          sx_d    = row_low;
          sy_d    = row_q;
        end
        if (row_q == Y_W'(IMG_H - 1)) begin
          if (area_sum == '0) begin
            state_d = DONE;
            error_d = 2'b01;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (!nb_found) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = TRACE;
            cur_x_d = sel_x;
            cur_y_d = sel_y;
            dir_d   = nb_dir;
            valid_d = 1'b1;
          end
        end
      end
      TRACE: begin
        if (cc.code_ready) begin
          perim_d = perim_inc;
          cur_x_d = sel_x;
          cur_y_d = sel_y;
          if (!first_vld_q) begin
            first_vld_d = 1'b1;
            first_d     = dir_q;
          end
          if (perim_inc == LEN_W'(MAX_LEN)) begin
            state_d    = DONE;
            error_d[1] = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            valid_d    = 1'b0;
          end else if (stop || !nb_found) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            valid_d = 1'b0;
          end else begin
            dir_d = nb_dir;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      found_q     <= 1'b0;
      area_q      <= '0;
      sx_q        <= '0;
      sy_q        <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      dir_q       <= '0;
      first_q     <= '0;
      first_vld_q <= 1'b0;
      valid_q     <= 1'b0;
      perim_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      found_q     <= found_d;
      area_q      <= area_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      dir_q       <= dir_d;
      first_q     <= first_d;
      first_vld_q <= first_vld_d;
      valid_q     <= valid_d;
      perim_q     <= perim_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

`ifdef CHAIN_DIFF_EN
  logic [2:0] code_q, code_d;

  // First code raw, later codes relative to the previously accepted direction.
  always_comb begin
    code_d = code_q;
    if (valid_d && state_q == SCAN) begin
      code_d = dir_d;
    end else if (valid_d && state_q == TRACE && cc.code_ready) begin
      code_d = dir_d - dir_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q <= '0;
    end else begin
      code_q <= code_d;
    end
  end

  assign cc.code = code_q;
`else
  assign cc.code = dir_q;
`endif

  assign cc.code_valid = valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign perimeter_o   = perim_q;
  assign area_o        = area_q;
  assign start_x_o     = sx_q;
  assign start_y_o     = sy_q;

endmodule

// File: doc/chain_code_tracer.md
Name: chain_code_tracer

Overview:
Parametrised successor to the 64x64 chain-code encoder. It holds a binary image of IMG_W x IMG_H pixels loaded row by row. It locates the boundary start pixel and computes the object area, then traces the outer boundary with 8-connected Moore tracing and streams Freeman codes over a valid/ready interface with backpressure. It sits between the image loader/BRAM reader and the chain-code consumer (UART/serialiser).

Parameters:
IMG_W, 64, image width in pixels (columns), 2..256
IMG_H, 64, image height in pixels (rows), 2..256
X_W, 6, column coordinate width, ceil(log2(IMG_W))
Y_W, 6, row coordinate width, ceil(log2(IMG_H))
LEN_W, 12, perimeter counter width; MAX_LEN = 2**LEN_W - 1 codes

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  write one image row; ignored unless busy=0
wr_row  in  Y_W  row index; wr_row>=IMG_H ignored
wr_data  in  IMG_W  row pixels, bit j = column j, 1 = object
start  in  1  1-cycle request; accepted only when busy=0
busy  out  1  high from accepted start until done
code  out  3  Freeman code: 0=E,1=NE,2=N,3=NW,4=W,5=SW,6=S,7=SE (N = row-1)
code_valid  out  1  code valid; held with code stable until code_ready
code_ready  in  1  consumer accepts code when valid&ready
done  out  1  level; high in DONE until next accepted start
error  out  2  bit0 empty image, bit1 perimeter overflow; valid when done
perimeter  out  LEN_W  number of codes emitted
area  out  X_W+Y_W+1  count of 1-pixels
start_x  out  X_W  start pixel column
start_y  out  Y_W  start pixel row

Behaviour:
- Reset: all outputs 0. State IDLE. Image memory is not cleared.
- Image memory is an IMG_H x IMG_W register array. It is written only while busy=0. Neighbours outside the image read as 0.
- FSM: IDLE -> SCAN -> TRACE -> DONE. DONE -> SCAN on start.
- Start accepted in IDLE or DONE. On acceptance, the next cycle clears done, error, perimeter, area and code_valid, and sets busy=1.
- SCAN: one row per cycle, rows 0..IMG_H-1, exactly IMG_H cycles.
  - area += popcount(row).
  - The first row with any set bit gives start_y = that row and start_x = lowest set column (raster order: topmost, then leftmost).
- After SCAN, if area==0: error=01 and go to DONE with no codes emitted.
- TRACE setup: cur = start, first = none, search start direction s = 5.
- TRACE step (combinational neighbour select):
  - Check directions s, s+1, ..., s+7 (mod 8). The first set neighbour gives code d.
  - If no neighbour is set (isolated pixel), go to DONE with perimeter 0 and error 0.
- Stop rule: if cur == start, first is recorded, and d == first, go to DONE without emitting.
- Otherwise:
  - Present d with code_valid=1.
  - On the handshake: record first (the first time), move cur by d, perimeter += 1, set s = (d+7) mod 8 if d is even, else (d+6) mod 8.
- Throughput: one code per cycle when code_ready is held high. The first code_valid asserts the cycle after SCAN ends.
- With code_ready=0, code and code_valid stay stable and the tracer stalls.
- Overflow: if a handshake makes perimeter reach MAX_LEN, set error bit1 and go to DONE.
- In DONE: busy=0, done=1, code_valid=0. area and start_x/start_y hold.
- A start received while busy=1 is ignored. wr_en while busy=1 is ignored.
- An asynchronous reset mid-trace returns to IDLE at once, drops code_valid, and discards the partial chain.

Optional Feature:
CHAIN_DIFF_EN
- Defined: code carries the differential chain code. The first code is raw; each later code is (d - previous d) mod 8, computed at handshake order. perimeter and stop rule are unchanged.
- Undefined: code carries absolute Freeman directions. The differential logic is not present.

Test Plan:
- Empty image, start -> done after IMG_H+1 cycles; error=01, area=0, perimeter=0, no code_valid.
- Single pixel at row 7, col 3 -> start_x=3, start_y=7, area=1, perimeter=0, error=00, no codes.
- 2x2 square at rows 10-11, cols 20-21, code_ready=1 -> codes 6,0,2,4; perimeter=4, area=4, start_x=20, start_y=10, error=00.
- Line at row 5, cols 0-2 (left image edge) -> codes 0,0,4,4; perimeter=4, area=3; out-of-bounds neighbours read as 0.
- 2x2 square with code_ready toggling 1 cycle on / 3 cycles off -> same sequence 6,0,2,4; code stable while valid&!ready; no duplicates or drops.
- Reset asserted during the 2nd code of the square -> next cycle: busy=0, code_valid=0, done=0. A re-start (image retained) yields the full 6,0,2,4.
